// File: rtl/processor_pkg.sv
// Shared constants for the processor data bus.
//   IO_BASE           : word address of the memory-mapped I/O page
//   IO_*              : register offsets within the I/O page
//   CTRL_*_BIT        : bit positions inside TIMER_CTRL
package processor_pkg;

    localparam int IO_BASE = 'h3FF00;

    localparam logic [7:0] IO_TIMER_COUNT   = 8'h00;
    localparam logic [7:0] IO_TIMER_COMPARE = 8'h01;
    localparam logic [7:0] IO_TIMER_CTRL    = 8'h02;
    localparam logic [7:0] IO_GPIO_OUT      = 8'h03;
    localparam logic [7:0] IO_GPIO_IN       = 8'h04;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MATCH_BIT  = 1;

endpackage

// File: rtl/data_timer.sv
// Free-running timer with compare match and wake pulse.
//   clock, reset           : system clock, async active-high reset
//   count_we/compare_we/ctrl_we : write strobes decoded by the parent
//   wdata                  : write data
//   count, compare         : current register values
//   enable, match          : TIMER_CTRL bits
//   wake_event             : one-cycle pulse the cycle after a match
module data_timer
    import processor_pkg::*;
#(
    parameter int WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 count_we,
    input  logic                 compare_we,
    input  logic                 ctrl_we,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] count,
    output logic [WORD_SIZE-1:0] compare,
    output logic                 enable,
    output logic                 match,
    output logic                 wake_event
);

    // Match is evaluated on the register values held during this cycle,
    // independent of any write landing at the coming edge.
    logic hit;
    assign hit = enable && (count == compare);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            compare    <= '0;
            enable     <= 1'b0;
            match      <= 1'b0;
            wake_event <= 1'b0;
        end else begin
            if (count_we)
                count <= wdata;
            else if (enable)
                count <= count + 1'b1;

            if (compare_we)
                compare <= wdata;

            if (ctrl_we)
                enable <= wdata[CTRL_ENABLE_BIT];

            // A fresh match beats a simultaneous write-1-to-clear.
            if (hit)
                match <= 1'b1;
            else if (ctrl_we && wdata[CTRL_MATCH_BIT])
                match <= 1'b0;

            wake_event <= hit;
        end
    end

endmodule

// File: rtl/processor_data_bus.sv
// Data-side responder for the processor memory port: on-chip RAM plus an
// I/O page (timer, GPIO out, synchronized GPIO in). Read data is registered
// and appears one cycle after the address.
//   clock, reset         : system clock, async active-high reset
//   memory_addr          : word address, valid every cycle
//   memory_write_enable  : write strobe
//   memory_in            : write data
//   memory_out           : read data for the previous cycle's address
//   gpio_in              : asynchronous external inputs
//   gpio_out             : GPIO_OUT register
//   wake_event           : timer match pulse
module processor_data_bus
    import processor_pkg::*;
#(
    parameter int ADDR_SIZE     = 18,
    parameter int WORD_SIZE     = 18,
    parameter int RAM_ADDR_BITS = 12,
    parameter int GPIO_IN_BITS  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_SIZE-1:0]    memory_addr,
    input  logic                    memory_write_enable,
    input  logic [WORD_SIZE-1:0]    memory_in,
    output logic [WORD_SIZE-1:0]    memory_out,
    input  logic [GPIO_IN_BITS-1:0] gpio_in,
    output logic [WORD_SIZE-1:0]    gpio_out,
    output logic                    wake_event
);

    localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;
    localparam logic [ADDR_SIZE-1:0] IO_BASE_ADDR = ADDR_SIZE'(IO_BASE);

    // Address decode: full compare of the upper bits so nothing aliases.
    logic       ram_sel, io_sel, io_we;
    logic [7:0] io_off;
    assign ram_sel = (memory_addr[ADDR_SIZE-1:RAM_ADDR_BITS] == '0);
    assign io_sel  = (memory_addr[ADDR_SIZE-1:8] == IO_BASE_ADDR[ADDR_SIZE-1:8]);
    assign io_off  = memory_addr[7:0];
    assign io_we   = memory_write_enable && io_sel;

    logic [WORD_SIZE-1:0] timer_count, timer_compare;
    logic                 timer_enable, timer_match;

    data_timer #(.WORD_SIZE(WORD_SIZE)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .count_we   (io_we && io_off == IO_TIMER_COUNT),
        .compare_we (io_we && io_off == IO_TIMER_COMPARE),
        .ctrl_we    (io_we && io_off == IO_TIMER_CTRL),
        .wdata      (memory_in),
        .count      (timer_count),
        .compare    (timer_compare),
        .enable     (timer_enable),
        .match      (timer_match),
        .wake_event (wake_event)
    );

    // Single-port read-first RAM; contents are not reset.
    logic [WORD_SIZE-1:0] ram [RAM_WORDS];
    logic [WORD_SIZE-1:0] ram_q;

    always_ff @(posedge clock) begin
        if (memory_write_enable && ram_sel)
            ram[memory_addr[RAM_ADDR_BITS-1:0]] <= memory_in;
        ram_q <= ram[memory_addr[RAM_ADDR_BITS-1:0]];
    end

    logic [GPIO_IN_BITS-1:0] gpio_meta, gpio_sync;

    // I/O read value from register state before this edge's writes.
    logic [WORD_SIZE-1:0] io_rdata;
    always_comb begin
        io_rdata = '0;
        case (io_off)
            IO_TIMER_COUNT:   io_rdata = timer_count;
            IO_TIMER_COMPARE: io_rdata = timer_compare;
            IO_TIMER_CTRL: begin
                io_rdata[CTRL_ENABLE_BIT] = timer_enable;
                io_rdata[CTRL_MATCH_BIT]  = timer_match;
            end
            IO_GPIO_OUT:      io_rdata = gpio_out;
            IO_GPIO_IN:       io_rdata = WORD_SIZE'(gpio_sync);
            default:          io_rdata = '0;
        endcase
    end

    // The RAM output register cannot be reset, so the output mux selects
    // from a resettable I/O register unless the last access hit RAM.
    // Unmapped reads leave both sel_ram_q and io_q at zero.
    logic                 sel_ram_q;
    logic [WORD_SIZE-1:0] io_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_ram_q <= 1'b0;
            io_q      <= '0;
            gpio_out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            sel_ram_q <= ram_sel;
            io_q      <= io_sel ? io_rdata : '0;
            if (io_we && io_off == IO_GPIO_OUT)
                gpio_out <= memory_in;
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
        end
    end

    assign memory_out = sel_ram_q ? ram_q : io_q;

endmodule

// File: tb/tb_processor_data_bus.sv
module tb_processor_data_bus;

    localparam logic [17:0] IO_PAGE = 18'h3FF00;
    localparam logic [17:0] A_COUNT = IO_PAGE + 18'h0;
    localparam logic [17:0] A_CMP   = IO_PAGE + 18'h1;
    localparam logic [17:0] A_CTRL  = IO_PAGE + 18'h2;
    localparam logic [17:0] A_GOUT  = IO_PAGE + 18'h3;
    localparam logic [17:0] A_GIN   = IO_PAGE + 18'h4;
    localparam logic [17:0] A_IDLE  = 18'h20000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] memory_addr = A_IDLE;
    logic        memory_write_enable = 1'b0;
    logic [17:0] memory_in = '0;
    logic [17:0] memory_out;
    logic [7:0]  gpio_in = '0;
    logic [17:0] gpio_out;
    logic        wake_event;

    int compared = 0;
    int mismatched = 0;

    processor_data_bus dut (
        .clock               (clock),
        .reset               (reset),
        .memory_addr         (memory_addr),
        .memory_write_enable (memory_write_enable),
        .memory_in           (memory_in),
        .memory_out          (memory_out),
        .gpio_in             (gpio_in),
        .gpio_out            (gpio_out),
        .wake_event          (wake_event)
    );

    always #5 clock = ~clock;

    // One bus cycle: present the access, take the edge, return 1ns later so
    // memory_out holds the read result of this very access.
    task automatic bus(input logic [17:0] a, input logic we, input logic [17:0] d);
        memory_addr = a;
        memory_write_enable = we;
        memory_in = d;
        @(posedge clock);
        #1;
        memory_addr = A_IDLE;
        memory_write_enable = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        compared++;
        if (memory_out !== 18'h0 || gpio_out !== 18'h0 || wake_event !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got out=%h gpio=%h wake=%b expected all 0",
                     memory_out, gpio_out, wake_event);
        end
        reset = 1'b0;
        bus(A_CTRL, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %h expected 0", memory_out);
        end
        bus(A_COUNT, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_count: got %h expected 0", memory_out);
        end
    endtask

    task automatic test_ram_basic;
        bus(18'h00010, 1'b1, 18'h2ABCD);
        bus(18'h00010, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h2ABCD) begin
            mismatched++;
            $display("FAIL ram_read: got %h expected 2abcd", memory_out);
        end
        bus(18'h01000, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h0) begin
            mismatched++;
            $display("FAIL unmapped_read: got %h expected 0", memory_out);
        end
    endtask

    task automatic test_read_first;
        bus(18'h00005, 1'b1, 18'h00111);
        bus(18'h00005, 1'b1, 18'h00222);
        compared++;
        if (memory_out !== 18'h00111) begin
            mismatched++;
            $display("FAIL read_first_old: got %h expected 00111", memory_out);
        end
        bus(18'h00005, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h00222) begin
            mismatched++;
            $display("FAIL read_first_new: got %h expected 00222", memory_out);
        end
    endtask

    // Random RAM and unmapped traffic against an associative-array memory.
    task automatic test_ram_random;
        logic [17:0] model [int];
        int          keys [$];
        logic [17:0] a, d;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    a = 18'($urandom_range(0, 4095));
                    d = 18'($urandom);
                    bus(a, 1'b1, d);
                    if (model.exists(int'(a))) begin
                        compared++;
                        if (memory_out !== model[int'(a)]) begin
                            mismatched++;
                            $display("FAIL rand_write_readfirst @%h: got %h expected %h",
                                     a, memory_out, model[int'(a)]);
                        end
                    end else begin
                        keys.push_back(int'(a));
                    end
                    model[int'(a)] = d;
                end
                2: begin
                    if (keys.size() > 0) begin
                        a = 18'(keys[$urandom_range(0, keys.size() - 1)]);
                        bus(a, 1'b0, '0);
                        compared++;
                        if (memory_out !== model[int'(a)]) begin
                            mismatched++;
                            $display("FAIL rand_read @%h: got %h expected %h",
                                     a, memory_out, model[int'(a)]);
                        end
                    end
                end
                default: begin
                    a = 18'($urandom_range('h01000, 'h3FEFF));
                    bus(a, 1'($urandom), 18'($urandom));
                    compared++;
                    if (memory_out !== 18'h0) begin
                        mismatched++;
                        $display("FAIL rand_unmapped @%h: got %h expected 0", a, memory_out);
                    end
                end
            endcase
        end
        // Unmapped writes whose low bits hit a RAM word must not alias into it.
        if (keys.size() > 0) begin
            a = 18'(keys[0]);
            bus(a | 18'h01000, 1'b1, ~model[keys[0]]);
            bus(a, 1'b0, '0);
            compared++;
            if (memory_out !== model[keys[0]]) begin
                mismatched++;
                $display("FAIL no_alias @%h: got %h expected %h", a, memory_out, model[keys[0]]);
            end
        end
    endtask

    task automatic test_timer_match;
        int pulses = 0;
        int first = -1;
        bus(A_CMP, 1'b1, 18'd10);
        bus(A_COUNT, 1'b1, 18'd0);
        bus(A_CTRL, 1'b1, 18'h1);
        // Counter is 0 after enabling; reaches 10 after ten edges, so the
        // match edge is the 11th and wake is seen after it.
        for (int k = 1; k <= 30; k++) begin
            bus(A_IDLE, 1'b0, '0);
            if (wake_event === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        compared++;
        if (pulses !== 1 || first !== 11) begin
            mismatched++;
            $display("FAIL wake_pulse: got pulses=%0d at=%0d expected 1 at 11", pulses, first);
        end
        bus(A_CTRL, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h3) begin
            mismatched++;
            $display("FAIL ctrl_after_match: got %h expected 3", memory_out);
        end
        // Clear match while keeping enable set.
        bus(A_CTRL, 1'b1, 18'h3);
        bus(A_CTRL, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h1) begin
            mismatched++;
            $display("FAIL ctrl_after_clear: got %h expected 1", memory_out);
        end
    endtask

    task automatic test_set_clear_collision;
        bus(A_CTRL, 1'b1, 18'h0);
        bus(A_COUNT, 1'b1, 18'd0);
        bus(A_CMP, 1'b1, 18'd3);
        bus(A_CTRL, 1'b1, 18'h1);
        repeat (3) bus(A_IDLE, 1'b0, '0);
        // Counter equals 3 in this cycle: clear and match land together.
        bus(A_CTRL, 1'b1, 18'h3);
        compared++;
        if (wake_event !== 1'b1) begin
            mismatched++;
            $display("FAIL collision_wake: got %b expected 1", wake_event);
        end
        bus(A_CTRL, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h3 || wake_event !== 1'b0) begin
            mismatched++;
            $display("FAIL collision_match: got ctrl=%h wake=%b expected ctrl=3 wake=0",
                     memory_out, wake_event);
        end
    endtask

    task automatic test_wrap_priority;
        bus(A_COUNT, 1'b1, 18'h3FFFF);
        bus(A_COUNT, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h3FFFF) begin
            mismatched++;
            $display("FAIL count_pre_increment: got %h expected 3ffff", memory_out);
        end
        bus(A_COUNT, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h0) begin
            mismatched++;
            $display("FAIL count_wrap: got %h expected 0", memory_out);
        end
        bus(A_COUNT, 1'b1, 18'd7);
        bus(A_COUNT, 1'b0, '0);
        compared++;
        if (memory_out !== 18'd7) begin
            mismatched++;
            $display("FAIL count_write_priority: got %h expected 7", memory_out);
        end
    endtask

    task automatic test_gpio;
        gpio_in = 8'hA5;
        repeat (2) bus(A_IDLE, 1'b0, '0);
        bus(A_GIN, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h000A5) begin
            mismatched++;
            $display("FAIL gpio_in_read: got %h expected 000a5", memory_out);
        end
        bus(A_GOUT, 1'b1, 18'h155);
        compared++;
        if (gpio_out !== 18'h155) begin
            mismatched++;
            $display("FAIL gpio_out_port: got %h expected 155", gpio_out);
        end
        bus(A_GOUT, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h155) begin
            mismatched++;
            $display("FAIL gpio_out_read: got %h expected 155", memory_out);
        end
    endtask

    task automatic test_async_reset;
        // memory_out currently holds 0x155 and gpio_out is 0x155.
        #3;
        reset = 1'b1;
        #1;
        compared++;
        if (memory_out !== 18'h0 || gpio_out !== 18'h0 || wake_event !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: got out=%h gpio=%h wake=%b expected all 0",
                     memory_out, gpio_out, wake_event);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus(A_CTRL, 1'b0, '0);
        compared++;
        if (memory_out !== 18'h0) begin
            mismatched++;
            $display("FAIL async_reset_ctrl: got %h expected 0", memory_out);
        end
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_read_first();
        test_ram_random();
        test_timer_match();
        test_set_clear_collision();
        test_wrap_priority();
        test_gpio();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
